// File: rtl/debug_sequencer_if.sv
// debug_sequencer_if: groups the UART byte handshake and the pipeline debug/enable bus
// of the debug sequencer.
//   master modport: the sequencer side (drives tx, instruction load, enables, debug reads)
//   slave  modport: the environment side (UART rx/tx pair and pipeline)
// Signals:
//   rx_data_i/rx_valid_i   received byte and its 1-cycle strobe
//   tx_busy_i              transmitter busy
//   tx_start_o/tx_data_o   1-cycle send strobe and byte to send
//   halt_i, pc_i, cycles_i pipeline status
//   reg_data_i/mem_data_i  debug read data
//   inst_o/inst_addr_o/inst_wr_o  instruction-memory load port
//   debug_mode_o, enable_pipe_o, enable_mem_o  pipeline ownership/advance
//   reg_addr_o/read_reg_o, mem_addr_o/read_mem_o  debug read requests
//   state_o                current sequencer state
interface debug_sequencer_if #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 10,
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned N_BITS  = 8
);
  logic [N_BITS-1:0]  rx_data_i;
  logic               rx_valid_i;
  logic               tx_busy_i;
  logic               tx_start_o;
  logic [N_BITS-1:0]  tx_data_o;
  logic               halt_i;
  logic [NB_ADDR-1:0] pc_i;
  logic [N_BITS-1:0]  cycles_i;
  logic [NB_DATA-1:0] reg_data_i;
  logic [NB_DATA-1:0] mem_data_i;
  logic [NB_DATA-1:0] inst_o;
  logic [NB_ADDR-1:0] inst_addr_o;
  logic               inst_wr_o;
  logic               debug_mode_o;
  logic               enable_pipe_o;
  logic               enable_mem_o;
  logic [NB_REG-1:0]  reg_addr_o;
  logic               read_reg_o;
  logic [NB_ADDR-1:0] mem_addr_o;
  logic               read_mem_o;
  logic [2:0]         state_o;

  modport master (
    input  rx_data_i, rx_valid_i, tx_busy_i, halt_i, pc_i, cycles_i, reg_data_i, mem_data_i,
    output tx_start_o, tx_data_o, inst_o, inst_addr_o, inst_wr_o, debug_mode_o, enable_pipe_o,
           enable_mem_o, reg_addr_o, read_reg_o, mem_addr_o, read_mem_o, state_o
  );

  modport slave (
    output rx_data_i, rx_valid_i, tx_busy_i, halt_i, pc_i, cycles_i, reg_data_i, mem_data_i,
    input  tx_start_o, tx_data_o, inst_o, inst_addr_o, inst_wr_o, debug_mode_o, enable_pipe_o,
           enable_mem_o, reg_addr_o, read_reg_o, mem_addr_o, read_mem_o, state_o
  );
endinterface

// File: rtl/debug_sequencer.sv
// debug_sequencer: UART-side controller for the segmented MIPS pipeline. Loads a program
// from a byte stream into instruction memory, runs the pipeline continuously or one step
// at a time, and after a halt or each step streams out PC, cycle count, register file and
// data memory byte-by-byte.
// Ports:
//   clock    system clock
//   reset_i  asynchronous active-low reset
//   bus      debug_sequencer_if.master (UART handshake + pipeline debug bus)
module debug_sequencer #(
  parameter int unsigned        NB_DATA     = 32,
  parameter int unsigned        NB_ADDR     = 10,
  parameter int unsigned        NB_REG      = 5,
  parameter int unsigned        N_BITS      = 8,
  parameter int unsigned        N_MEM_WORDS = 32,
  parameter logic [NB_DATA-1:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input logic               clock,
  input logic               reset_i,
  debug_sequencer_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, WAIT_CMD = 3'd2, RUN = 3'd3;
  localparam logic [2:0] STEP_WAIT = 3'd4, STEP = 3'd5, DUMP = 3'd6, DONE = 3'd7;
  // Dump sub-phases: read request, capture, byte pulse, ignored cycle, wait for busy to fall
  localparam logic [2:0] PH_FETCH = 3'd0, PH_CAPT = 3'd1, PH_SEND = 3'd2;
  localparam logic [2:0] PH_GAP = 3'd3, PH_HOLD = 3'd4;

  localparam logic [N_BITS-1:0] CMD_L = 8'h4C, CMD_C = 8'h43, CMD_S = 8'h53, CMD_N = 8'h4E;

  // Frame items: 0 = PC, 1 = cycles, then registers, then memory words
  localparam int unsigned NItems = 2 + 2 ** NB_REG + N_MEM_WORDS;
  localparam int unsigned IW = $clog2(NItems);
  localparam logic [IW-1:0] ITEM_PC = IW'(0);
  localparam logic [IW-1:0] ITEM_CYC = IW'(1);
  localparam logic [IW-1:0] FIRST_REG = IW'(2);
  localparam logic [IW-1:0] FIRST_MEM = IW'(2 + 2 ** NB_REG);
  localparam logic [IW-1:0] LAST_ITEM = IW'(NItems - 1);
  localparam logic [NB_ADDR-1:0] ADDR_MAX = '1;

  logic [2:0]         state_q, state_d;
  logic [1:0]         lbyte_q, lbyte_d;
  logic [NB_DATA-1:0] inst_q, inst_d;
  logic [NB_ADDR-1:0] inst_addr_q, inst_addr_d;
  logic               inst_wr_q, inst_wr_d;
  logic               debug_mode_q, debug_mode_d;
  logic               halted_q, halted_d;
  logic [IW-1:0]      item_q, item_d;
  logic [1:0]         dbyte_q, dbyte_d;
  logic [2:0]         phase_q, phase_d;
  logic [NB_DATA-1:0] word_q, word_d;

  logic rx_l, rx_c, rx_s, rx_n;
  logic last_byte, reading;

  assign rx_l = bus.rx_valid_i && (bus.rx_data_i == CMD_L);
  assign rx_c = bus.rx_valid_i && (bus.rx_data_i == CMD_C);
  assign rx_s = bus.rx_valid_i && (bus.rx_data_i == CMD_S);
  assign rx_n = bus.rx_valid_i && (bus.rx_data_i == CMD_N);

  // The cycles item is a single byte; every other item is a full word
  assign last_byte = (item_q == ITEM_CYC) || (dbyte_q == 2'd3);
  assign reading   = (state_q == DUMP) && ((phase_q == PH_FETCH) || (phase_q == PH_CAPT));

  always_comb begin
    state_d      = state_q;
    lbyte_d      = lbyte_q;
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    inst_wr_d    = 1'b0;
    debug_mode_d = debug_mode_q;
    halted_d     = halted_q;
    item_d       = item_q;
    dbyte_d      = dbyte_q;
    phase_d      = phase_q;
    word_d       = word_q;
    case (state_q)
      IDLE, DONE: begin
        if (rx_l) begin
          state_d      = LOAD;
          inst_addr_d  = '0;
          lbyte_d      = 2'd0;
          debug_mode_d = 1'b1;
          halted_d     = 1'b0;
        end
      end
      LOAD: begin
        if (inst_wr_q) begin
          // Halt word or full memory ends the load without advancing the address
          if ((inst_q == HALT_WORD) || (inst_addr_q == ADDR_MAX)) state_d = WAIT_CMD;
          else inst_addr_d = inst_addr_q + NB_ADDR'(1);
        end else if (bus.rx_valid_i) begin
          inst_d    = {bus.rx_data_i, inst_q[NB_DATA-1:N_BITS]};
          lbyte_d   = lbyte_q + 2'd1;
          inst_wr_d = (lbyte_q == 2'd3);
        end
      end
      WAIT_CMD: begin
        if (rx_c) begin
          state_d      = RUN;
          debug_mode_d = 1'b0;
        end else if (rx_s) begin
          state_d      = STEP_WAIT;
          debug_mode_d = 1'b0;
        end
      end
      RUN: begin
        if (bus.halt_i) begin
          state_d      = DUMP;
          halted_d     = 1'b1;
          debug_mode_d = 1'b1;
          item_d       = '0;
          dbyte_d      = 2'd0;
          phase_d      = PH_FETCH;
        end
      end
      STEP_WAIT: begin
        if (rx_n) begin
          state_d      = STEP;
          debug_mode_d = 1'b0;
        end
      end
      STEP: begin
        state_d      = DUMP;
        halted_d     = bus.halt_i;
        debug_mode_d = 1'b1;
        item_d       = '0;
        dbyte_d      = 2'd0;
        phase_d      = PH_FETCH;
      end
      DUMP: begin
        case (phase_q)
          PH_FETCH: phase_d = PH_CAPT;
          PH_CAPT: begin
            if (item_q == ITEM_PC) word_d = NB_DATA'(bus.pc_i);
            else if (item_q == ITEM_CYC) word_d = NB_DATA'(bus.cycles_i);
            else if (item_q < FIRST_MEM) word_d = bus.reg_data_i;
            else word_d = bus.mem_data_i;
            phase_d = PH_SEND;
          end
          PH_SEND: if (!bus.tx_busy_i) phase_d = PH_GAP;
          PH_GAP:  phase_d = PH_HOLD;
          PH_HOLD: begin
            // tx_data_o may only move once busy has fallen after the pulse
            if (!bus.tx_busy_i) begin
              if (!last_byte) begin
                dbyte_d = dbyte_q + 2'd1;
                phase_d = PH_SEND;
              end else if (item_q == LAST_ITEM) begin
                state_d = halted_q ? DONE : STEP_WAIT;
              end else begin
                item_d  = item_q + IW'(1);
                dbyte_d = 2'd0;
                phase_d = PH_FETCH;
              end
            end
          end
          default: phase_d = PH_FETCH;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      lbyte_q      <= 2'd0;
      inst_q       <= '0;
      inst_addr_q  <= '0;
      inst_wr_q    <= 1'b0;
      debug_mode_q <= 1'b0;
      halted_q     <= 1'b0;
      item_q       <= '0;
      dbyte_q      <= 2'd0;
      phase_q      <= PH_FETCH;
      word_q       <= '0;
    end else begin
      state_q      <= state_d;
      lbyte_q      <= lbyte_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      inst_wr_q    <= inst_wr_d;
      debug_mode_q <= debug_mode_d;
      halted_q     <= halted_d;
      item_q       <= item_d;
      dbyte_q      <= dbyte_d;
      phase_q      <= phase_d;
      word_q       <= word_d;
    end
  end

  always_comb begin
    bus.tx_data_o = word_q[N_BITS-1:0];
    case (dbyte_q)
      2'd1:    bus.tx_data_o = word_q[N_BITS*1 +: N_BITS];
      2'd2:    bus.tx_data_o = word_q[N_BITS*2 +: N_BITS];
      2'd3:    bus.tx_data_o = word_q[N_BITS*3 +: N_BITS];
      default: bus.tx_data_o = word_q[N_BITS-1:0];
    endcase
  end

  assign bus.tx_start_o    = (state_q == DUMP) && (phase_q == PH_SEND) && !bus.tx_busy_i;
  assign bus.inst_o        = inst_q;
  assign bus.inst_addr_o   = inst_addr_q;
  assign bus.inst_wr_o     = inst_wr_q;
  assign bus.debug_mode_o  = debug_mode_q;
  assign bus.enable_pipe_o = ((state_q == RUN) && !bus.halt_i) || (state_q == STEP);
  assign bus.enable_mem_o  = bus.enable_pipe_o;
  assign bus.read_reg_o    = reading && (item_q >= FIRST_REG) && (item_q < FIRST_MEM);
  assign bus.read_mem_o    = reading && (item_q >= FIRST_MEM);
  assign bus.reg_addr_o    = bus.read_reg_o ? NB_REG'(item_q - FIRST_REG) : '0;
  assign bus.mem_addr_o    = bus.read_mem_o ? NB_ADDR'(item_q - FIRST_MEM) : '0;
  assign bus.state_o       = state_q;
endmodule
